// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store unit and its data-memory port:
// access-size codes, FSM state codes and byte-enable patterns.
package dmem_pkg;

  localparam int DW = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_misaligned(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    return (sz == SIZE_HALF && lo[0]) ||
           (sz == SIZE_WORD && lo != 2'b00) ||
           (sz == SIZE_ILL);
  endfunction

endpackage

// File: rtl/lsu_dmem_if_if.sv
// Data-memory bus bundle: request side driven by the LSU,
// grant/response side driven by the memory.
import dmem_pkg::*;

interface dmem_bus_if;
  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [3:0]    be;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_dmem_if_align.sv
// Store lane steering with byte-enable generation, and load
// lane extraction with sign/zero extension.
import dmem_pkg::*;

module lsu_align (
  input  logic [1:0]    i_size,
  input  logic [1:0]    i_lo,
  input  logic          i_unsigned,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] lane;
  logic          sgn;

  always_comb begin
    lane    = i_rdata >> {i_lo, 3'b000};
    sgn     = 1'b0;
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = lane;
    unique case (1'b1)
      (i_size == SIZE_BYTE): begin
        sgn     = lane[7] & ~i_unsigned;
        o_be    = BE_BYTE << i_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{sgn}}, lane[7:0]};
      end
      (i_size == SIZE_HALF): begin
        sgn     = lane[15] & ~i_unsigned;
        o_be    = BE_HALF << i_lo;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{sgn}}, lane[15:0]};
      end
      (i_size == SIZE_WORD): begin
        o_be    = BE_WORD;
        o_rdata = i_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit front end: runs the req/gnt/rvalid handshake on the
// data-memory port and stalls the pipeline until the access completes.
import dmem_pkg::*;

module lsu_dmem_if #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [1:0]      i_d_size,
  input  logic            i_d_unsigned,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_stall,
  output logic            o_misaligned,
  output logic            o_bus_err,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
  localparam logic          TO_EN  = (TIMEOUT_CYCLES != 0);

  dmem_bus_if bus ();

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            we_q, we_d;

  logic            access, we_in, mis, idle, to_hit;
  logic            req, stall, misal, berr, rnew;
  logic [1:0]      a_size;
  logic [XLEN-1:0] a_addr, a_wdata;
  logic            a_uns, a_we;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;

  assign access = i_mem_read | i_mem_write;
  assign we_in  = i_mem_write & ~i_mem_read;
  assign mis    = access && is_misaligned(i_d_size, i_addr[1:0]);
  assign idle   = (state_q == ST_IDLE);
  assign to_hit = TO_EN && (cnt_q == TO_LIM);

  // IDLE drives the bus straight from the inputs; later states replay
  // the captured access so the bus stays stable while stalled.
  assign a_size  = idle ? i_d_size     : size_q;
  assign a_addr  = idle ? i_addr       : addr_q;
  assign a_wdata = idle ? i_wdata      : wdata_q;
  assign a_uns   = idle ? i_d_unsigned : uns_q;
  assign a_we    = idle ? we_in        : we_q;

  lsu_align u_align (
    .i_size     (a_size),
    .i_lo       (a_addr[1:0]),
    .i_unsigned (a_uns),
    .i_wdata    (a_wdata),
    .i_rdata    (bus.rdata),
    .o_be       (al_be),
    .o_wdata    (al_wdata),
    .o_rdata    (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    req     = 1'b0;
    stall   = 1'b0;
    misal   = 1'b0;
    berr    = 1'b0;
    rnew    = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        cnt_d = '0;
        if (mis) begin
          misal = 1'b1;
        end else if (access) begin
          req     = 1'b1;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          size_d  = i_d_size;
          uns_d   = i_d_unsigned;
          we_d    = we_in;
          if (!bus.gnt) begin
            stall   = 1'b1;
            state_d = ST_REQ;
          end else if (!we_in) begin
            stall   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      (state_q == ST_REQ): begin
        req = 1'b1;
        if (bus.gnt) begin
          cnt_d   = '0;
          state_d = we_q ? ST_IDLE : ST_WAIT;
          stall   = ~we_q;
        end else if (to_hit) begin
          req     = 1'b0;
          berr    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      (state_q == ST_WAIT): begin
        if (bus.rvalid) begin
          rnew    = 1'b1;
          rdata_d = al_rdata;
          state_d = ST_IDLE;
        end else if (to_hit) begin
          berr    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
    end
  end

  assign bus.req    = req & i_rst_n;
  assign bus.we     = bus.req & a_we;
  assign bus.addr   = bus.req ? {a_addr[XLEN-1:2], 2'b00} : '0;
  assign bus.be     = bus.req ? al_be : 4'b0000;
  assign bus.wdata  = bus.req ? al_wdata : '0;
  assign bus.gnt    = i_dmem_gnt;
  assign bus.rvalid = i_dmem_rvalid;
  assign bus.rdata  = i_dmem_rdata;

  assign o_dmem_req   = bus.req;
  assign o_dmem_we    = bus.we;
  assign o_dmem_addr  = bus.addr;
  assign o_dmem_be    = bus.be;
  assign o_dmem_wdata = bus.wdata;

  assign o_stall      = stall & i_rst_n;
  assign o_misaligned = misal & i_rst_n;
  assign o_bus_err    = berr & i_rst_n;
  assign o_rdata      = !i_rst_n ? '0 :
                        rnew     ? al_rdata : rdata_q;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: stores, loads, misalignment,
// handshake timeout and reset during an outstanding load.
module tb_lsu_dmem_if;
  import dmem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write, d_uns;
  logic [1:0]  d_size;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misal, berr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_rd;

  dmem_bus_if bus ();

  lsu_dmem_if #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_d_size      (d_size),
    .i_d_unsigned  (d_uns),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_stall       (stall),
    .o_misaligned  (misal),
    .o_bus_err     (berr),
    .o_dmem_req    (bus.req),
    .o_dmem_we     (bus.we),
    .o_dmem_addr   (bus.addr),
    .o_dmem_be     (bus.be),
    .o_dmem_wdata  (bus.wdata),
    .i_dmem_gnt    (bus.gnt),
    .i_dmem_rvalid (bus.rvalid),
    .i_dmem_rdata  (bus.rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    d_size     = SIZE_WORD;
    d_uns      = 1'b0;
    addr       = 32'h0;
    wdata      = 32'h0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr();
    mem_read = 1'b1;
    bus.gnt  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.req, stall, misal, berr} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl got=%b want=0000",
               {bus.req, stall, misal, berr});
    end
    n_cmp++;
    if (rdata !== 32'h0 || bus.be !== 4'h0) begin
      n_err++;
      $display("FAIL reset_data rdata=%h be=%b want 0", rdata, bus.be);
    end
    @(negedge clk);
    clr();
    rst_n = 1'b1;
    last_rd = 32'h0;
  endtask

  task automatic test_sw();
    @(negedge clk);
    mem_write = 1'b1;
    d_size    = SIZE_WORD;
    addr      = 32'h100;
    wdata     = 32'hDEADBEEF;
    bus.gnt   = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req, bus.we, bus.be, stall} !== 7'b1_1_1111_0) begin
      n_err++;
      $display("FAIL sw_ctl req/we/be/stall=%b want 1111110",
               {bus.req, bus.we, bus.be, stall});
    end
    n_cmp++;
    if (bus.wdata !== 32'hDEADBEEF || bus.addr !== 32'h100) begin
      n_err++;
      $display("FAIL sw_bus wdata=%h addr=%h want deadbeef/100",
               bus.wdata, bus.addr);
    end
    @(negedge clk);
    clr();
    #1;
    n_cmp++;
    if (bus.req !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL sw_after req=%b stall=%b want 0/0", bus.req, stall);
    end
  endtask

  task automatic test_sb_delay();
    @(negedge clk);
    mem_write = 1'b1;
    d_size    = SIZE_BYTE;
    addr      = 32'h103;
    wdata     = 32'h000000A5;
    #1;
    n_cmp++;
    if ({bus.req, bus.be, stall} !== 6'b1_1000_1 ||
        bus.wdata !== 32'hA5A5A5A5 || bus.addr !== 32'h100) begin
      n_err++;
      $display("FAIL sb_c0 req/be/stall=%b wdata=%h addr=%h",
               {bus.req, bus.be, stall}, bus.wdata, bus.addr);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      addr    = 32'h0000_0204;
      wdata   = 32'h1111_1111;
      bus.gnt = (i == 3);
      #1;
      n_cmp++;
      if ({bus.req, bus.we, bus.be} !== 6'b1_1_1000 ||
          bus.wdata !== 32'hA5A5A5A5 || bus.addr !== 32'h100 ||
          stall !== (i != 3)) begin
        n_err++;
        $display("FAIL sb_c%0d req/we/be=%b wdata=%h addr=%h stall=%b",
                 i, {bus.req, bus.we, bus.be}, bus.wdata, bus.addr, stall);
      end
    end
    @(negedge clk);
    clr();
    #1;
    n_cmp++;
    if (bus.req !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL sb_done req=%b stall=%b want 0/0", bus.req, stall);
    end
  endtask

  task automatic do_load(input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp_d,
                         input logic [3:0] exp_be);
    @(negedge clk);
    mem_read = 1'b1;
    d_size   = sz;
    d_uns    = u;
    addr     = a;
    bus.gnt  = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req, bus.we, bus.be, stall} !== {2'b10, exp_be, 1'b1} ||
        bus.addr !== {a[31:2], 2'b00}) begin
      n_err++;
      $display("FAIL ld_req@%h req/we/be/stall=%b addr=%h want be=%b",
               a, {bus.req, bus.we, bus.be, stall}, bus.addr, exp_be);
    end
    @(negedge clk);
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = rd;
    #1;
    n_cmp++;
    if (rdata !== exp_d || stall !== 1'b0 || bus.req !== 1'b0) begin
      n_err++;
      $display("FAIL ld_data@%h rdata=%h stall=%b req=%b want %h/0/0",
               a, rdata, stall, bus.req, exp_d);
    end
    @(negedge clk);
    clr();
    bus.rdata = 32'h5555_AAAA;
    #1;
    n_cmp++;
    if (rdata !== exp_d || stall !== 1'b0) begin
      n_err++;
      $display("FAIL ld_hold@%h rdata=%h stall=%b want %h/0",
               a, rdata, stall, exp_d);
    end
    last_rd = exp_d;
  endtask

  task automatic test_loads();
    do_load(SIZE_BYTE, 1'b0, 32'h102, 32'h0080_0000,
            32'hFFFF_FF80, 4'b0100);
    do_load(SIZE_BYTE, 1'b1, 32'h102, 32'h0080_0000,
            32'h0000_0080, 4'b0100);
    do_load(SIZE_HALF, 1'b0, 32'h102, 32'h8001_0000,
            32'hFFFF_8001, 4'b1100);
    do_load(SIZE_HALF, 1'b1, 32'h102, 32'h8001_0000,
            32'h0000_8001, 4'b1100);
    do_load(SIZE_WORD, 1'b0, 32'h104, 32'h1234_5678,
            32'h1234_5678, 4'b1111);
  endtask

  task automatic test_misaligned();
    logic [1:0]  szs [3];
    logic [31:0] ads [3];
    szs = '{SIZE_WORD, SIZE_HALF, SIZE_ILL};
    ads = '{32'h101, 32'h103, 32'h100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_read = 1'b1;
      d_size   = szs[i];
      addr     = ads[i];
      bus.gnt  = 1'b1;
      #1;
      n_cmp++;
      if ({misal, bus.req, stall} !== 3'b100) begin
        n_err++;
        $display("FAIL mis%0d mis/req/stall=%b want 100",
                 i, {misal, bus.req, stall});
      end
      @(negedge clk);
      clr();
      #1;
      n_cmp++;
      if ({misal, bus.req, stall} !== 3'b000) begin
        n_err++;
        $display("FAIL mis%0d_after mis/req/stall=%b want 000",
                 i, {misal, bus.req, stall});
      end
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    mem_read = 1'b1;
    d_size   = SIZE_WORD;
    addr     = 32'h200;
    bus.gnt  = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.gnt = 1'b0;
      #1;
      n_cmp++;
      if ({berr, stall, bus.req} !== 3'b010) begin
        n_err++;
        $display("FAIL to_wait%0d err/stall/req=%b want 010",
                 i, {berr, stall, bus.req});
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({berr, stall, bus.req} !== 3'b100 || rdata !== last_rd) begin
      n_err++;
      $display("FAIL to_err err/stall/req=%b rdata=%h want 100/%h",
               {berr, stall, bus.req}, rdata, last_rd);
    end
    @(negedge clk);
    clr();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if (rdata !== last_rd || berr !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL to_late rdata=%h err=%b stall=%b want %h/0/0",
               rdata, berr, stall, last_rd);
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_read = 1'b1;
    d_size   = SIZE_WORD;
    addr     = 32'h300;
    bus.gnt  = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL rm_wait stall=%b want 1", stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req, stall} !== 2'b00 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rm_async req/stall=%b rdata=%h want 00/0",
               {bus.req, stall}, rdata);
    end
    @(negedge clk);
    clr();
    rst_n      = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (rdata !== 32'h0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rm_late rdata=%h stall=%b want 0/0", rdata, stall);
    end
    do_load(SIZE_WORD, 1'b0, 32'h300, 32'h0BAD_F00D,
            32'h0BAD_F00D, 4'b1111);
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_delay();
    test_loads();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
- Load/store unit that consumes the main control unit's memory-control outputs (mem_read, mem_write, d_size, d_unsigned) and executes the access on the data-memory bus.
- Steers store bytes into lanes, generates byte enables, and sign- or zero-extends load data.
- Runs a req/gnt/rvalid handshake and stalls the core until the access completes.
- Sits between the EX/MEM stage and the dmem port.

Parameters:
- XLEN, 32, data and address width (only 32 is supported)
- TIMEOUT_CYCLES, 255, maximum cycles to wait in REQ or WAIT before a bus error is raised; 0 disables the timeout

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mem_read  in  1  load request from the control unit
- i_mem_write  in  1  store request from the control unit
- i_d_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- i_d_unsigned  in  1  zero-extend load data
- i_addr  in  XLEN  byte address from the ALU
- i_wdata  in  XLEN  store data (rs2)
- o_rdata  out  XLEN  extended load result
- o_stall  out  1  hold the pipeline
- o_misaligned  out  1  one-cycle pulse: misaligned or illegal-size access
- o_bus_err  out  1  one-cycle pulse: handshake timeout
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2], 2'b00})
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  XLEN  lane-steered store data
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  XLEN  read data

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n is low: state = IDLE, timeout counter = 0, captured rdata register = 0, and every output is 0.
- Access exists when i_mem_read or i_mem_write is high. If both are high, the access is treated as a read.
- Misaligned conditions: size 01 with addr[0]=1; size 10 with addr[1:0]!=0; size 11 always.
- Store lanes:
  - Byte: wdata = 4 copies of wdata[7:0]; be = 0001 << addr[1:0].
  - Half: wdata = 2 copies of wdata[15:0]; be = 0011 << addr[1:0].
  - Word: wdata unchanged; be = 1111.
  - For reads, be shows the lanes being read, using the same encoding.
- Load extract: lane = rdata >> (8*addr[1:0]), then for byte or half, extend from bit 7 or bit 15 (zero-extend if unsigned, sign-extend otherwise). Word passes through unchanged.
- FSM states are IDLE, REQ and WAIT.
- IDLE:
  - Misaligned access: no request; o_misaligned=1 for one cycle; o_stall=0; stay in IDLE.
  - Aligned access: in the same cycle, drive o_dmem_req=1 and the bus fields combinationally from the inputs; capture addr[1:0], size, unsigned and we into registers.
    - gnt=1 and store: stall=0, stay in IDLE (one-cycle store).
    - gnt=1 and load: stall=1, go to WAIT.
    - gnt=0: stall=1, go to REQ.
- REQ:
  - Hold req and all bus fields stable from the captured registers until gnt.
  - On gnt, a store finishes with stall=0 that cycle and the FSM goes to IDLE; a load goes to WAIT with stall held at 1.
- WAIT:
  - req=0 and stall=1 until rvalid.
  - On rvalid: o_rdata = extended i_dmem_rdata combinationally, stall=0, load the rdata register, go to IDLE.
  - rvalid may arrive in the cycle immediately after gnt; minimum load latency is 2 cycles.
- o_rdata outside the rvalid cycle: holds the last captured value.
- Ignored handshakes: rvalid in IDLE or REQ, and gnt in IDLE with no access or in WAIT.
- Timeout:
  - The counter clears on entry to REQ or WAIT and increments every cycle spent there.
  - When it reaches TIMEOUT_CYCLES, o_bus_err pulses for 1 cycle, stall=0, req drops, and the FSM goes to IDLE.
  - A late rvalid after the timeout is ignored.
- Reset mid-operation: the FSM returns to IDLE immediately and req drops asynchronously; a pending rvalid is later ignored.

Decomposition:
- Shared package dmem_pkg: size codes (SIZE_BYTE/HALF/WORD), FSM state enum, be/lane helper constants.
- One combinational sub-module, lsu_align, handles store lane steering with be generation and load extract/extend. The FSM, counter and registers stay in lsu_dmem_if.

Test Plan:
- SW 0xDEADBEEF at addr 0x100, gnt in the same cycle -> be=1111, wdata=0xDEADBEEF, dmem_addr=0x100, stall=0 that cycle.
- SB wdata=0x000000A5 at addr 0x103, gnt delayed 3 cycles -> req held stable, be=1000, wdata=0xA5A5A5A5, stall=1 for 3 cycles, 0 on the gnt cycle.
- LB at addr 0x102 and LBU at addr 0x102, rdata=0x0080_0000 -> o_rdata=0xFFFFFF80 and 0x00000080 respectively. LH at addr 0x102 with rdata=0x8001_0000 -> o_rdata=0xFFFF8001.
- LW at addr 0x101 and LH at addr 0x103 -> o_misaligned pulse, o_dmem_req never high, stall=0.
- LW with gnt but no rvalid, TIMEOUT_CYCLES=4 -> o_bus_err pulses after 4 WAIT cycles, FSM returns to IDLE, a later rvalid does not change o_rdata.
- Deassert i_rst_n while in WAIT -> req, stall and o_rdata go to 0 immediately; after release the next LW completes normally.
